// File: rtl/rd_pack_stream_if.sv
// Handshake bundle between the FIFO read port / downstream sink and rd_pack_stream.
// The master side drives the FIFO status, flush and sink ready; the slave side is the packer.
interface rd_pack_stream_if #(
  parameter int DW   = 8,
  parameter int PACK = 2
);
  localparam int MW = $clog2(PACK) + 1;

  logic              rrdy;
  logic [DW-1:0]     rdata;
  logic              rget;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  logic [DW*PACK-1:0] m_data;
  logic [MW-1:0]     m_words;

  modport master (
    output rrdy, rdata, flush, m_ready,
    input  rget, m_valid, m_data, m_words
  );

  modport slave (
    input  rrdy, rdata, flush, m_ready,
    output rget, m_valid, m_data, m_words
  );
endinterface

// File: rtl/rd_pack_stream.sv
// Read-domain packer: pops DW-bit words from the CDC FIFO read port, packs PACK
// words little-endian into one beat and presents beats through a two-entry buffer.
module rd_pack_stream #(
  parameter int DW   = 8,
  parameter int PACK = 2
) (
  input logic           rclk,
  input logic           rrst,
  rd_pack_stream_if.slave bus
);
  localparam int BW = DW * PACK;
  localparam int MW = $clog2(PACK) + 1;

  logic [BW-1:0] acc, acc_nx;
  logic [MW-1:0] cnt, cnt_nx;
  logic          flush_pend, flush_pend_nx;
  logic          rel;
  logic [1:0]    occ;
  logic [BW-1:0] head_data, skid_data;
  logic [MW-1:0] head_words, skid_words;

  logic          space, accept, pop, push;
  logic [BW-1:0] push_data;
  logic [MW-1:0] push_words;

  assign space       = (occ != 2'd2);
  assign bus.rget    = rel & bus.rrdy & ~flush_pend & ((cnt != MW'(PACK - 1)) | space);
  assign accept      = bus.rrdy & bus.rget;
  assign pop         = (occ != 2'd0) & bus.m_ready;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head_data;
  assign bus.m_words = head_words;

  // Reset-release gate keeping rget low for the first cycle after reset.
  always_ff @(posedge rclk) begin
    if (rrst) rel <= 1'b0;
    else      rel <= 1'b1;
  end

  // Word accept, beat completion and flush resolution.
  // The flush decision uses the post-accept count, so a completing accept
  // leaves nothing to flush and the two never produce two pushes.
  always_comb begin
    acc_nx        = acc;
    cnt_nx        = cnt;
    flush_pend_nx = flush_pend;
    push          = 1'b0;
    push_data     = '0;
    push_words    = '0;
    if (accept) begin
      for (int unsigned i = 0; i < PACK; i++) begin
        if (cnt == MW'(i)) acc_nx[i*DW +: DW] = bus.rdata;
      end
      if (cnt == MW'(PACK - 1)) begin
        push       = 1'b1;
        push_data  = acc_nx;
        push_words = MW'(PACK);
        cnt_nx     = '0;
        acc_nx     = '0;
      end else begin
        cnt_nx = cnt + MW'(1);
      end
    end
    if (bus.flush | flush_pend) begin
      if (cnt_nx == '0) begin
        flush_pend_nx = 1'b0;
      end else if (space) begin
        push          = 1'b1;
        push_data     = acc_nx;
        push_words    = cnt_nx;
        cnt_nx        = '0;
        acc_nx        = '0;
        flush_pend_nx = 1'b0;
      end else begin
        flush_pend_nx = 1'b1;
      end
    end
  end

  // Accumulator, word count and pending-flush registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_nx;
      cnt        <= cnt_nx;
      flush_pend <= flush_pend_nx;
    end
  end

  // Two-entry output buffer; head drives the stream, skid holds the second beat.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ        <= 2'd0;
      head_data  <= '0;
      head_words <= '0;
      skid_data  <= '0;
      skid_words <= '0;
    end else begin
      if (push && !pop) begin
        if (occ == 2'd0) begin
          head_data  <= push_data;
          head_words <= push_words;
        end else begin
          skid_data  <= push_data;
          skid_words <= push_words;
        end
        occ <= occ + 2'd1;
      end else if (pop && !push) begin
        if (occ == 2'd2) begin
          head_data  <= skid_data;
          head_words <= skid_words;
        end
        occ <= occ - 2'd1;
      end else if (push && pop) begin
        if (occ == 2'd1) begin
          head_data  <= push_data;
          head_words <= push_words;
        end else begin
          head_data  <= skid_data;
          head_words <= skid_words;
          skid_data  <= push_data;
          skid_words <= push_words;
        end
      end
    end
  end
endmodule

// File: tb/tb_rd_pack_stream.sv
// Directed bench for rd_pack_stream (DW=8, PACK=2) with a queue-modelled FIFO.
module tb_rd_pack_stream;
  localparam int DW   = 8;
  localparam int PACK = 2;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  rd_pack_stream_if #(.DW(DW), .PACK(PACK)) bus ();
  rd_pack_stream #(.DW(DW), .PACK(PACK)) dut (.rclk(rclk), .rrst(rrst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int gets   = 0;
  int vcnt   = 0;
  logic [7:0]  fq[$];
  logic [15:0] od[$];
  logic [1:0]  ow[$];

  task automatic refresh();
    bus.rrdy  = (fq.size() != 0);
    bus.rdata = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic clear_obs();
    od.delete(); ow.delete(); gets = 0; vcnt = 0;
  endtask

  // One cycle: sample mid-cycle, take the edge, then update the FIFO model.
  task automatic step();
    logic got;
    #4;
    got = bus.rrdy && bus.rget;
    if (got) gets++;
    if (bus.m_valid) vcnt++;
    if (bus.m_valid && bus.m_ready) begin
      od.push_back(bus.m_data);
      ow.push_back(bus.m_words);
    end
    @(posedge rclk); #1;
    if (got) void'(fq.pop_front());
    refresh();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
    checks++; if (bus.m_words !== 2'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", bus.m_words); end
    checks++; if (bus.m_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.m_data); end
    fq.push_back(8'h11); fq.push_back(8'h22); refresh();
    #1;
    checks++; if (bus.rget !== 1'b0) begin errors++; $display("FAIL reset_rget_held: got %b want 0", bus.rget); end
    step();
    rrst = 1'b0;
    #1;
    checks++; if (bus.rget !== 1'b0) begin errors++; $display("FAIL reset_rget_gate: got %b want 0", bus.rget); end
  endtask

  task automatic test_basic();
    clear_obs();
    bus.m_ready = 1'b1;
    repeat (5) step();
    checks++; if (gets !== 2) begin errors++; $display("FAIL basic_gets: got %0d want 2", gets); end
    checks++; if (vcnt !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", vcnt); end
    checks++; if (od.size() !== 1) begin errors++; $display("FAIL basic_beats: got %0d want 1", od.size()); end
    else begin
      checks++; if (od[0] !== 16'h2211) begin errors++; $display("FAIL basic_data: got %h want 2211", od[0]); end
      checks++; if (ow[0] !== 2'd2) begin errors++; $display("FAIL basic_words: got %0d want 2", ow[0]); end
    end
  endtask

  task automatic test_partial_flush();
    logic [15:0] ed[2];
    logic [1:0]  ew[2];
    ed = '{16'h00A5, 16'h0201}; ew = '{2'd1, 2'd2};
    clear_obs();
    fq.push_back(8'hA5); refresh();
    step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h00A5 || bus.m_words !== 2'd1) begin
      errors++; $display("FAIL flush_latency: got v=%b d=%h w=%0d want v=1 d=00a5 w=1", bus.m_valid, bus.m_data, bus.m_words);
    end
    fq.push_back(8'h01); fq.push_back(8'h02); refresh();
    repeat (4) step();
    checks++; if (od.size() !== 2) begin errors++; $display("FAIL flush_beats: got %0d want 2", od.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++; if (od[i] !== ed[i] || ow[i] !== ew[i]) begin
        errors++; $display("FAIL flush_beat%0d: got %h/%0d want %h/%0d", i, od[i], ow[i], ed[i], ew[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ed[3];
    ed = '{16'h0201, 16'h0403, 16'h0605};
    clear_obs();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) fq.push_back(8'(i));
    refresh();
    repeat (8) step();
    checks++; if (bus.rget !== 1'b0 || bus.rrdy !== 1'b1) begin
      errors++; $display("FAIL bp_stall: got rget=%b rrdy=%b want rget=0 rrdy=1", bus.rget, bus.rrdy);
    end
    checks++; if (fq.size() !== 1) begin errors++; $display("FAIL bp_pending: got %0d want 1", fq.size()); end
    checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h0201) begin
      errors++; $display("FAIL bp_head_hold: got v=%b d=%h want v=1 d=0201", bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    repeat (8) step();
    checks++; if (od.size() !== 3) begin errors++; $display("FAIL bp_beats: got %0d want 3", od.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (od[i] !== ed[i] || ow[i] !== 2'd2) begin
        errors++; $display("FAIL bp_beat%0d: got %h/%0d want %h/2", i, od[i], ow[i], ed[i]);
      end
    end
    checks++; if (fq.size() !== 0 || bus.m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got fifo=%0d v=%b want 0 0", fq.size(), bus.m_valid);
    end
  endtask

  task automatic test_flush_full();
    logic [15:0] ed[4];
    logic [1:0]  ew[4];
    ed = '{16'h2010, 16'h4030, 16'h007E, 16'h0055};
    ew = '{2'd2, 2'd2, 2'd1, 2'd1};
    clear_obs();
    bus.m_ready = 1'b0;
    fq.push_back(8'h10); fq.push_back(8'h20); fq.push_back(8'h30);
    fq.push_back(8'h40); fq.push_back(8'h7E); refresh();
    repeat (7) step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    fq.push_back(8'h55); refresh();
    #1;
    checks++; if (bus.rget !== 1'b0) begin errors++; $display("FAIL ff_rget: got %b want 0", bus.rget); end
    bus.m_ready = 1'b1;
    repeat (6) step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    repeat (3) step();
    checks++; if (od.size() !== 4) begin errors++; $display("FAIL ff_beats: got %0d want 4", od.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (od[i] !== ed[i] || ow[i] !== ew[i]) begin
        errors++; $display("FAIL ff_beat%0d: got %h/%0d want %h/%0d", i, od[i], ow[i], ed[i], ew[i]);
      end
    end
  endtask

  task automatic test_simul_flush();
    clear_obs();
    bus.m_ready = 1'b1;
    fq.push_back(8'h33); refresh();
    step();
    fq.push_back(8'h44); refresh();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    repeat (3) step();
    checks++; if (od.size() !== 1) begin errors++; $display("FAIL simul_beats: got %0d want 1", od.size()); end
    else begin
      checks++; if (od[0] !== 16'h4433 || ow[0] !== 2'd2) begin
        errors++; $display("FAIL simul_beat: got %h/%0d want 4433/2", od[0], ow[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    bus.m_ready = 1'b0;
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03); refresh();
    repeat (3) step();
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b want 1", bus.m_valid); end
    rrst = 1'b1; step(); rrst = 1'b0;
    fq.push_back(8'h0A); fq.push_back(8'h0B); refresh();
    #1;
    checks++; if (bus.m_valid !== 1'b0 || bus.m_words !== 2'd0 || bus.rget !== 1'b0) begin
      errors++; $display("FAIL rm_after_reset: got v=%b w=%0d rget=%b want 0 0 0", bus.m_valid, bus.m_words, bus.rget);
    end
    bus.m_ready = 1'b1;
    repeat (5) step();
    checks++; if (od.size() !== 1) begin errors++; $display("FAIL rm_beats: got %0d want 1", od.size()); end
    else begin
      checks++; if (od[0] !== 16'h0B0A || ow[0] !== 2'd2) begin
        errors++; $display("FAIL rm_beat: got %h/%0d want 0b0a/2", od[0], ow[0]);
      end
    end
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    refresh();
    @(posedge rclk); #1;
    test_reset();
    test_basic();
    test_partial_flush();
    test_backpressure();
    test_flush_full();
    test_simul_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
